raw_window_buf: RTL and testbench

- Parametrised successor to the raw hit delay line.
- Continuously writes WIDTH-bit raw hit frames into a circular block-RAM buffer and outputs each frame again after a programmable delay.
- Adds a trigger-captured readout window with pre/post-trigger depth, streamed out over a valid/ready handshake for the DAQ readout path.
- Sits between the input hit latches and both the pattern finder and the raw-hit readout FIFO.

---
 rtl/raw_buf_pkg.sv | 28 ++
 rtl/raw_window_buf_if.sv | 12 +
 rtl/raw_dpram.sv | 19 +
 rtl/raw_window_buf.sv | 161 ++++++++++++++++
 tb/tb_raw_window_buf.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/raw_buf_pkg.sv
// Shared types and clamp helpers for the raw hit window buffer.
package raw_buf_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    POST  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned MIN_DELAY = 2;
  localparam int unsigned WIN_GUARD = 4;

  function automatic int unsigned eff_delay(input int unsigned d);
    return (d < MIN_DELAY) ? MIN_DELAY : d;
  endfunction

  // Window length is capped so the captured frames are never overwritten while draining.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    if (len < 1) return 1;
    if (len > depth - WIN_GUARD) return depth - WIN_GUARD;
    return len;
  endfunction

  function automatic int unsigned clamp_pre(input int unsigned pre, input int unsigned len);
    return (pre > len - 1) ? len - 1 : pre;
  endfunction

endpackage

// File: rtl/raw_window_buf_if.sv
// Valid/ready readout stream carrying captured window frames.
interface raw_window_buf_if #(
  parameter int unsigned WIDTH = 192
);
  logic [WIDTH-1:0] rd_dat;
  logic             rd_vld;
  logic             rd_rdy;
  logic             rd_last;

  modport master (output rd_dat, output rd_vld, output rd_last, input rd_rdy);
  modport slave  (input rd_dat, input rd_vld, input rd_last, output rd_rdy);
endinterface

// File: rtl/raw_dpram.sv
// Simple dual-port block RAM: one write port, one synchronous read port (read-old on collision).
module raw_dpram #(
  parameter int unsigned WIDTH = 192,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  (* ram_style = "block" *) logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/raw_window_buf.sv
// Circular raw-frame buffer: programmable delay line plus trigger-captured readout window.
module raw_window_buf
  import raw_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 192,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             we,
  input  logic [AW-1:0]    delay,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             trig,
  input  logic [AW-1:0]    win_len,
  input  logic [AW-1:0]    win_pre,
  raw_window_buf_if.master rd,
  output logic             busy,
  output logic             trig_lost
);
  localparam int unsigned DEPTH = 1 << AW;

  state_t           state_q, state_d;
  logic [AW-1:0]    adw_q, adw_d, fill_q, fill_d, tptr_q, tptr_d;
  logic [AW-1:0]    len_q, len_d, pre_q, pre_d, post_q, post_d, iss_q, iss_d;
  logic             p1_q, p1_d, p1_last_q, p1_last_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic             fwp_q, fwp_d, frp_q, frp_d;
  logic             byp_sel_q, byp_sel_d, lost_q, lost_d;
  logic [WIDTH-1:0] ram_q, byp_q, dout_q;
  logic [WIDTH-1:0] fdat_q [2];
  logic             flast_q [2];

  logic             wen, vld, last, pop, push, issue;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    d_eff, dly_addr, raddr, len_c, pre_c, post_c;
  logic [1:0]       occ;

  raw_dpram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wen),
    .waddr (adw_q),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_comb begin
    wen      = (state_q != DRAIN);
    wdata    = we ? din : '0;
    d_eff    = AW'(eff_delay(32'(delay)));
    // Two cycles of read latency are absorbed by reading MIN_DELAY frames ahead.
    dly_addr = adw_q - d_eff + AW'(MIN_DELAY);
    len_c    = AW'(clamp_len(32'(win_len), DEPTH));
    pre_c    = AW'(clamp_pre(32'(win_pre), 32'(len_c)));
    post_c   = len_c - pre_c - AW'(1);
    vld      = (fcnt_q != 2'd0);
    last     = vld & flast_q[frp_q];
    pop      = vld & rd.rd_rdy;
    push     = p1_q;
    occ      = fcnt_q + {1'b0, p1_q};
    issue    = (state_q == DRAIN) && (iss_q != len_q) && ((occ - {1'b0, pop}) < 2'd2);
    raddr    = (state_q == DRAIN) ? (tptr_q - pre_q + iss_q) : dly_addr;

    state_d   = state_q;
    adw_d     = wen ? adw_q + AW'(1) : adw_q;
    fill_d    = (wen && (fill_q != '1)) ? fill_q + AW'(1) : fill_q;
    tptr_d    = tptr_q;
    len_d     = len_q;
    pre_d     = pre_q;
    post_d    = post_q;
    iss_d     = issue ? iss_q + AW'(1) : iss_q;
    p1_d      = issue;
    p1_last_d = issue && (iss_q == len_q - AW'(1));
    fcnt_d    = fcnt_q + {1'b0, push} - {1'b0, pop};
    fwp_d     = push ? ~fwp_q : fwp_q;
    frp_d     = pop ? ~frp_q : frp_q;
    byp_sel_d = wen && (dly_addr == adw_q);
    lost_d    = lost_q | (trig && (state_q != RUN));

    case (state_q)
      RUN: begin
        if (trig) begin
          len_d   = len_c;
          pre_d   = pre_c;
          tptr_d  = adw_q;
          post_d  = post_c;
          iss_d   = '0;
          state_d = (post_c == '0) ? DRAIN : POST;
        end
      end
      POST: begin
        post_d = post_q - AW'(1);
        if (post_q == AW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && last) begin
          state_d = RUN;
          fill_d  = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      adw_q     <= '0;
      fill_q    <= '0;
      tptr_q    <= '0;
      len_q     <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      iss_q     <= '0;
      p1_q      <= 1'b0;
      p1_last_q <= 1'b0;
      fcnt_q    <= '0;
      fwp_q     <= 1'b0;
      frp_q     <= 1'b0;
      byp_sel_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      adw_q     <= adw_d;
      fill_q    <= fill_d;
      tptr_q    <= tptr_d;
      len_q     <= len_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      iss_q     <= iss_d;
      p1_q      <= p1_d;
      p1_last_q <= p1_last_d;
      fcnt_q    <= fcnt_d;
      fwp_q     <= fwp_d;
      frp_q     <= frp_d;
      byp_sel_q <= byp_sel_d;
      lost_q    <= lost_d;
    end
  end

  // At minimum delay the read hits the address being written; forward the write data instead.
  always_ff @(posedge clk) begin
    byp_q  <= wdata;
    dout_q <= byp_sel_q ? byp_q : ram_q;
    if (push) begin
      fdat_q[fwp_q]  <= ram_q;
      flast_q[fwp_q] <= p1_last_q;
    end
  end

  assign dout_vld   = (state_q != DRAIN) && (fill_q >= d_eff);
  assign dout       = dout_vld ? dout_q : '0;
  assign rd.rd_vld  = vld;
  assign rd.rd_dat  = vld ? fdat_q[frp_q] : '0;
  assign rd.rd_last = last;
  assign busy       = (state_q != RUN);
  assign trig_lost  = lost_q;

endmodule

// File: tb/tb_raw_window_buf.sv
// Directed scoreboard bench for raw_window_buf: delay line, capture windows, backpressure, reset abort.
module tb_raw_window_buf;
  localparam int unsigned W  = 192;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, we, trig;
  logic [W-1:0]  din, dout;
  logic [AW-1:0] delay, win_len, win_pre;
  logic          dout_vld, busy, trig_lost;

  always #5 clk = ~clk;

  raw_window_buf_if #(.WIDTH(W)) rif ();

  raw_window_buf #(.WIDTH(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .we        (we),
    .delay     (delay),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .trig      (trig),
    .win_len   (win_len),
    .win_pre   (win_pre),
    .rd        (rif),
    .busy      (busy),
    .trig_lost (trig_lost)
  );

  typedef enum int {M_RUN, M_POST, M_DRAIN} mst_t;

  int           checks = 0;
  int           errors = 0;
  mst_t         m_st;
  int           m_post, m_adw, d_cur, dcnt, fno, n_xfer;
  bit           exp_lost, hold_v;
  logic [W-1:0] held;
  logic [W-1:0] dq[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] hist[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at a falling edge with reset released.
  task automatic do_reset(input int dl);
    rst_n = 1'b0;
    trig  = 1'b0;
    rif.rd_rdy = 1'b0;
    delay = AW'(dl);
    d_cur = (dl < 2) ? 2 : dl;
    #1;
    chk1("rst_rd_vld", rif.rd_vld, 1'b0);
    chk1("rst_rd_last", rif.rd_last, 1'b0);
    chkw("rst_rd_dat", rif.rd_dat, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_trig_lost", trig_lost, 1'b0);
    chk1("rst_dout_vld", dout_vld, 1'b0);
    chkw("rst_dout", dout, '0);
    m_st = M_RUN; m_adw = 0; m_post = 0; dcnt = 0;
    exp_lost = 1'b0; hold_v = 1'b0; n_xfer = 0;
    dq.delete(); wq.delete(); hist.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check outputs left by the previous edge, drive the next inputs, model the edge.
  task automatic step(input bit trg, input bit rdy, input bit wbit);
    logic [W-1:0] e, f;
    bit           xfer, lastx, wr;
    int           L, P;
    chk1("busy", busy, m_st != M_RUN);
    chk1("trig_lost", trig_lost, exp_lost);
    if (m_st != M_DRAIN && dq.size() >= d_cur) begin
      chk1("dout_vld", dout_vld, 1'b1);
      e = dq.pop_front();
      chkw("dout", dout, e);
    end else begin
      chk1("dout_vld", dout_vld, 1'b0);
      chkw("dout_zero", dout, '0);
    end
    if (m_st == M_DRAIN) begin
      dcnt++;
      if (dcnt < 3) chk1("rd_vld_early", rif.rd_vld, 1'b0);
      else if (dcnt == 3) chk1("rd_vld_rise", rif.rd_vld, 1'b1);
    end
    if (hold_v) begin
      chk1("hold_vld", rif.rd_vld, 1'b1);
      chkw("hold_dat", rif.rd_dat, held);
    end
    xfer  = rif.rd_vld && rdy;
    lastx = 1'b0;
    if (xfer) begin
      chk1("win_pending", wq.size() > 0, 1'b1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chkw("rd_dat", rif.rd_dat, e);
        lastx = (wq.size() == 0);
        chk1("rd_last", rif.rd_last, lastx);
        n_xfer++;
      end
    end
    hold_v = rif.rd_vld && !rdy;
    held   = rif.rd_dat;

    f    = wbit ? W'(fno) : '0;
    din  = W'(fno);
    we   = wbit;
    trig = trg;
    rif.rd_rdy = rdy;

    wr = (m_st != M_DRAIN);
    if (trg && m_st != M_RUN) exp_lost = 1'b1;
    case (m_st)
      M_RUN: if (trg) begin
        L = (win_len == 0) ? 1 : ((int'(win_len) > 252) ? 252 : int'(win_len));
        P = (int'(win_pre) > L - 1) ? L - 1 : int'(win_pre);
        for (int i = P; i >= 1; i--) wq.push_back(hist[hist.size() - i]);
        wq.push_back(f);
        m_post = L - P - 1;
        m_st   = (m_post == 0) ? M_DRAIN : M_POST;
        dcnt   = 0;
      end
      M_POST: begin
        wq.push_back(f);
        m_post--;
        if (m_post == 0) begin
          m_st = M_DRAIN;
          dcnt = 0;
        end
      end
      default: if (lastx) begin
        m_st = M_RUN;
        dq.delete();
      end
    endcase
    if (wr) begin
      dq.push_back(f);
      hist.push_back(f);
      if (hist.size() > 300) void'(hist.pop_front());
      m_adw = (m_adw + 1) % 256;
    end
    fno++;
    @(negedge clk);
  endtask

  task automatic run_drain(input bit stall, input bit ltrig);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int g = 0;
    while (m_st != M_RUN && g < 200) begin
      step(ltrig && (m_st == M_DRAIN), stall ? pat[g % 4] : 1'b1, 1'b1);
      g++;
    end
    chk1("drain_done", m_st == M_RUN, 1'b1);
    chk1("window_empty", wq.size() == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b1; trig = 1'b0; din = '0; fno = 0;
    delay = AW'(5); win_len = AW'(8); win_pre = AW'(3);
    rif.rd_rdy = 1'b0;
    @(negedge clk);

    do_reset(5);
    repeat (20) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    do_reset(0);
    repeat (12) step(1'b0, 1'b0, 1'b1);

    do_reset(255);
    repeat (270) step(1'b0, 1'b0, 1'b1);

    // Capture around frame 100, no backpressure, then check fill restart.
    do_reset(5);
    fno = 0;
    while (fno < 100) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_drain(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b1);

    repeat (12) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_drain(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b1);

    win_len = AW'(0); win_pre = AW'(7);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_drain(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1);

    // Window straddling the 255->0 address wrap, with triggers throughout the drain.
    do_reset(5);
    win_len = AW'(12); win_pre = AW'(5);
    while (m_adw != 254) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_drain(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b1);

    do_reset(5);
    win_len = AW'(8); win_pre = AW'(3);
    repeat (20) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    n_xfer = 0;
    for (int g = 0; g < 50 && n_xfer < 3; g++) step(1'b0, 1'b1, 1'b1);
    chk1("three_xfers", n_xfer == 3, 1'b1);
    do_reset(5);
    repeat (30) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_drain(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
